fft_out_serializer: RTL and testbench

- Unloads 8-point FFT/IFFT result frames into a one-sample-per-beat stream toward downstream consumers.
- Sits directly after the fft_8pt output registers, which present y0..y7 (real and imag) in parallel, natural bin order.
- Double-buffered (ping-pong) with valid/ready handshakes on both sides.
- Optional bit-reversed emission order and arithmetic output scaling.

---
 rtl/fft_out_serializer_if.sv | 34 +++
 rtl/fft_out_serializer.sv | 118 +++++++++++
 tb/tb_fft_out_serializer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_out_serializer_if.sv
// Bus bundle for fft_out_serializer: the parallel frame input with its
// handshake, the serial sample output with its handshake, and status.
interface fft_out_serializer_if;
   logic signed [15:0] y0_r, y1_r, y2_r, y3_r, y4_r, y5_r, y6_r, y7_r;
   logic signed [15:0] y0_i, y1_i, y2_i, y3_i, y4_i, y5_i, y6_i, y7_i;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] out_r;
   logic signed [15:0] out_i;
   logic [2:0]         out_idx;
   logic               out_last;
   logic               out_valid;
   logic               out_ready;
   logic               overflow;
   logic [1:0]         dbg_count;

   // Producer and consumer side (testbench / surrounding system)
   modport master (
      output y0_r, y1_r, y2_r, y3_r, y4_r, y5_r, y6_r, y7_r,
      output y0_i, y1_i, y2_i, y3_i, y4_i, y5_i, y6_i, y7_i,
      output in_valid, out_ready,
      input  in_ready, out_r, out_i, out_idx, out_last, out_valid,
      input  overflow, dbg_count
   );

   // Serializer side
   modport slave (
      input  y0_r, y1_r, y2_r, y3_r, y4_r, y5_r, y6_r, y7_r,
      input  y0_i, y1_i, y2_i, y3_i, y4_i, y5_i, y6_i, y7_i,
      input  in_valid, out_ready,
      output in_ready, out_r, out_i, out_idx, out_last, out_valid,
      output overflow, dbg_count
   );
endinterface

// File: rtl/fft_out_serializer.sv
// Ping-pong buffered serializer for 8-point FFT result frames.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and out_* stay stable while
// out_valid is high and out_ready is low.
// dbg_count exposes the number of buffered frames (0..2) for checkers.
module fft_out_serializer #(
   parameter int SHIFT   = 0,
   parameter bit BIT_REV = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   fft_out_serializer_if.slave  bus
);

   logic signed [15:0] y_r [8];
   logic signed [15:0] y_i [8];

   assign y_r[0] = bus.y0_r;  assign y_i[0] = bus.y0_i;
   assign y_r[1] = bus.y1_r;  assign y_i[1] = bus.y1_i;
   assign y_r[2] = bus.y2_r;  assign y_i[2] = bus.y2_i;
   assign y_r[3] = bus.y3_r;  assign y_i[3] = bus.y3_i;
   assign y_r[4] = bus.y4_r;  assign y_i[4] = bus.y4_i;
   assign y_r[5] = bus.y5_r;  assign y_i[5] = bus.y5_i;
   assign y_r[6] = bus.y6_r;  assign y_i[6] = bus.y6_i;
   assign y_r[7] = bus.y7_r;  assign y_i[7] = bus.y7_i;

   logic signed [15:0] buf_r_q [2][8];
   logic signed [15:0] buf_r_d [2][8];
   logic signed [15:0] buf_i_q [2][8];
   logic signed [15:0] buf_i_d [2][8];
   logic [1:0]         count_q, count_d;
   logic               wr_sel_q, wr_sel_d;
   logic               rd_sel_q, rd_sel_d;
   logic [2:0]         rd_cnt_q, rd_cnt_d;
   logic               overflow_q, overflow_d;

   logic               in_ready;
   logic               out_valid;
   logic               push;
   logic               pop;
   logic               last_pop;
   logic [2:0]         rd_idx;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = bus.in_valid && in_ready;
   assign pop       = out_valid && bus.out_ready;
   assign last_pop  = pop && (rd_cnt_q == 3'd7);
   assign rd_idx    = BIT_REV ? {rd_cnt_q[0], rd_cnt_q[1], rd_cnt_q[2]} : rd_cnt_q;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_idx   = rd_idx;
   assign bus.out_last  = (rd_cnt_q == 3'd7);
   assign bus.out_r     = buf_r_q[rd_sel_q][rd_idx] >>> SHIFT;
   assign bus.out_i     = buf_i_q[rd_sel_q][rd_idx] >>> SHIFT;
   assign bus.overflow  = overflow_q;
   assign bus.dbg_count = count_q;

   // Next state: capture into the write buffer, advance the read beat, and
   // keep the frame count consistent when capture and release coincide.
   always_comb begin
      buf_r_d    = buf_r_q;
      buf_i_d    = buf_i_q;
      wr_sel_d   = wr_sel_q;
      rd_sel_d   = rd_sel_q;
      rd_cnt_d   = rd_cnt_q;
      count_d    = count_q;
      overflow_d = overflow_q | (bus.in_valid & ~in_ready);

      if (push) begin
         for (int k = 0; k < 8; k++) begin
            buf_r_d[wr_sel_q][k] = y_r[k];
            buf_i_d[wr_sel_q][k] = y_i[k];
         end
         wr_sel_d = ~wr_sel_q;
      end

      if (pop) begin
         rd_cnt_d = rd_cnt_q + 3'd1;
      end
      if (last_pop) begin
         rd_sel_d = ~rd_sel_q;
      end

      case ({push, last_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards any buffered frames immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 8; k++) begin
               buf_r_q[b][k] <= '0;
               buf_i_q[b][k] <= '0;
            end
         end
         count_q    <= '0;
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         rd_cnt_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         buf_r_q    <= buf_r_d;
         buf_i_q    <= buf_i_d;
         count_q    <= count_d;
         wr_sel_q   <= wr_sel_d;
         rd_sel_q   <= rd_sel_d;
         rd_cnt_q   <= rd_cnt_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Testbench for fft_out_serializer. Two instances share one stimulus:
// dut0 (SHIFT=0, natural order) and dut1 (SHIFT=2, bit-reversed order).
module tb_fft_out_serializer;

   typedef struct packed {
      logic [7:0][15:0] r;
      logic [7:0][15:0] i;
   } frame_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic   in_valid = 1'b0;
   logic   out_ready = 1'b0;
   frame_t drv_f = '0;

   fft_out_serializer_if bus0 ();
   fft_out_serializer_if bus1 ();

   assign bus0.in_valid = in_valid;   assign bus1.in_valid = in_valid;
   assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;
   assign bus0.y0_r = drv_f.r[0]; assign bus1.y0_r = drv_f.r[0];
   assign bus0.y1_r = drv_f.r[1]; assign bus1.y1_r = drv_f.r[1];
   assign bus0.y2_r = drv_f.r[2]; assign bus1.y2_r = drv_f.r[2];
   assign bus0.y3_r = drv_f.r[3]; assign bus1.y3_r = drv_f.r[3];
   assign bus0.y4_r = drv_f.r[4]; assign bus1.y4_r = drv_f.r[4];
   assign bus0.y5_r = drv_f.r[5]; assign bus1.y5_r = drv_f.r[5];
   assign bus0.y6_r = drv_f.r[6]; assign bus1.y6_r = drv_f.r[6];
   assign bus0.y7_r = drv_f.r[7]; assign bus1.y7_r = drv_f.r[7];
   assign bus0.y0_i = drv_f.i[0]; assign bus1.y0_i = drv_f.i[0];
   assign bus0.y1_i = drv_f.i[1]; assign bus1.y1_i = drv_f.i[1];
   assign bus0.y2_i = drv_f.i[2]; assign bus1.y2_i = drv_f.i[2];
   assign bus0.y3_i = drv_f.i[3]; assign bus1.y3_i = drv_f.i[3];
   assign bus0.y4_i = drv_f.i[4]; assign bus1.y4_i = drv_f.i[4];
   assign bus0.y5_i = drv_f.i[5]; assign bus1.y5_i = drv_f.i[5];
   assign bus0.y6_i = drv_f.i[6]; assign bus1.y6_i = drv_f.i[6];
   assign bus0.y7_i = drv_f.i[7]; assign bus1.y7_i = drv_f.i[7];

   fft_out_serializer #(.SHIFT(0), .BIT_REV(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   fft_out_serializer #(.SHIFT(2), .BIT_REV(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   int checks = 0;
   int failures = 0;

   // ---------------- reference model ----------------
   frame_t exp_q[$];          // frames held by the serializer, oldest first
   int     mdl_beat = 0;      // beats already delivered from exp_q[0]
   bit     mdl_ovf = 1'b0;
   int     beats_seen = 0;
   int     lasts_seen = 0;
   int     rev_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   function automatic int fdiv(input int x, input int s);
      int d;
      d = 1 << s;
      if (x >= 0) return x / d;
      return -((-x + d - 1) / d);
   endfunction

   task automatic model_clear();
      exp_q.delete();
      mdl_beat = 0;
      mdl_ovf = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      int n;
      int k1;
      frame_t f;
      logic signed [15:0] e_r0, e_i0, e_r1, e_i1;
      if (reset) begin
         n = exp_q.size();
         checks++;
         if (bus0.in_ready !== (n < 2) || bus1.in_ready !== (n < 2)) begin
            failures++;
            $display("FAIL sb_in_ready got=%0b/%0b exp=%0b", bus0.in_ready, bus1.in_ready, n < 2);
         end
         checks++;
         if (bus0.out_valid !== (n != 0) || bus1.out_valid !== (n != 0)) begin
            failures++;
            $display("FAIL sb_out_valid got=%0b/%0b exp=%0b", bus0.out_valid, bus1.out_valid, n != 0);
         end
         checks++;
         if (bus0.overflow !== mdl_ovf || bus1.overflow !== mdl_ovf) begin
            failures++;
            $display("FAIL sb_overflow got=%0b/%0b exp=%0b", bus0.overflow, bus1.overflow, mdl_ovf);
         end
         if (n != 0) begin
            f = exp_q[0];
            k1 = rev_tab[mdl_beat];
            e_r0 = 16'(fdiv(int'($signed(f.r[mdl_beat])), 0));
            e_i0 = 16'(fdiv(int'($signed(f.i[mdl_beat])), 0));
            e_r1 = 16'(fdiv(int'($signed(f.r[k1])), 2));
            e_i1 = 16'(fdiv(int'($signed(f.i[k1])), 2));
            checks++;
            if (bus0.out_idx !== 3'(mdl_beat) || bus0.out_r !== e_r0 || bus0.out_i !== e_i0 ||
                bus0.out_last !== (mdl_beat == 7)) begin
               failures++;
               $display("FAIL sb_beat_dut0 got idx=%0d r=%0d i=%0d last=%0b exp idx=%0d r=%0d i=%0d last=%0b",
                        bus0.out_idx, bus0.out_r, bus0.out_i, bus0.out_last, mdl_beat, e_r0, e_i0, mdl_beat == 7);
            end
            checks++;
            if (bus1.out_idx !== 3'(k1) || bus1.out_r !== e_r1 || bus1.out_i !== e_i1 ||
                bus1.out_last !== (mdl_beat == 7)) begin
               failures++;
               $display("FAIL sb_beat_dut1 got idx=%0d r=%0d i=%0d last=%0b exp idx=%0d r=%0d i=%0d last=%0b",
                        bus1.out_idx, bus1.out_r, bus1.out_i, bus1.out_last, k1, e_r1, e_i1, mdl_beat == 7);
            end
            if (out_ready) begin
               beats_seen++;
               if (mdl_beat == 7) lasts_seen++;
               mdl_beat++;
               if (mdl_beat == 8) begin
                  mdl_beat = 0;
                  void'(exp_q.pop_front());
               end
            end
         end
         if (in_valid) begin
            if (n < 2) exp_q.push_back(drv_f);
            else       mdl_ovf = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_frame();
      for (int k = 0; k < 8; k++) begin
         drv_f.r[k] = 16'($urandom);
         drv_f.i[k] = 16'($urandom);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      model_clear();
      cyc(2);
      reset = 1'b1;
      cyc(1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      #1;
      checks++;
      if (bus0.out_valid !== 1'b0 || bus0.overflow !== 1'b0 || bus0.out_r !== 16'sd0 ||
          bus0.out_i !== 16'sd0 || bus0.out_idx !== 3'd0 || bus0.out_last !== 1'b0 ||
          bus0.dbg_count !== 2'd0) begin
         failures++;
         $display("FAIL reset_outputs got valid=%0b ovf=%0b r=%0d i=%0d idx=%0d last=%0b cnt=%0d exp all 0",
                  bus0.out_valid, bus0.overflow, bus0.out_r, bus0.out_i, bus0.out_idx, bus0.out_last, bus0.dbg_count);
      end
      do_reset();
      checks++;
      if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%0b/%0b exp=1", bus0.in_ready, bus1.in_ready);
      end
   endtask

   task automatic test_single_frame();
      int b0;
      int l0;
      bit rdy_ok;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drv_f.r[k] = 16'(100 * k);
         drv_f.i[k] = 16'(-k);
      end
      b0 = beats_seen;
      l0 = lasts_seen;
      out_ready = 1'b1;
      in_valid = 1'b1;
      cyc(1);
      in_valid = 1'b0;
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out_idx !== 3'd0 || bus0.out_r !== 16'sd0) begin
         failures++;
         $display("FAIL single_first_beat got valid=%0b idx=%0d r=%0d exp valid=1 idx=0 r=0",
                  bus0.out_valid, bus0.out_idx, bus0.out_r);
      end
      rdy_ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (bus0.in_ready !== 1'b1) rdy_ok = 1'b0;
         cyc(1);
      end
      checks++;
      if (beats_seen - b0 != 8 || lasts_seen - l0 != 1) begin
         failures++;
         $display("FAIL single_beats got beats=%0d lasts=%0d exp beats=8 lasts=1", beats_seen - b0, lasts_seen - l0);
      end
      checks++;
      if (!rdy_ok) begin
         failures++;
         $display("FAIL single_in_ready got=0 exp=1");
      end
   endtask

   task automatic test_backpressure();
      int b0;
      int c;
      bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      rand_frame();
      b0 = beats_seen;
      in_valid = 1'b1;
      out_ready = pat[0];
      cyc(1);
      in_valid = 1'b0;
      c = 1;
      while (exp_q.size() != 0 && c < 60) begin
         out_ready = pat[c % 4];
         cyc(1);
         c++;
      end
      out_ready = 1'b0;
      cyc(2);
      checks++;
      if (beats_seen - b0 != 8 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL backpressure_beats got=%0d exp=8 (left=%0d)", beats_seen - b0, exp_q.size());
      end
   endtask

   task automatic test_overflow();
      int b0;
      do_reset();
      out_ready = 1'b0;
      b0 = beats_seen;
      rand_frame(); in_valid = 1'b1; cyc(1);
      checks++;
      if (bus0.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ovf_ready_after_a got=%0b exp=1", bus0.in_ready);
      end
      rand_frame(); cyc(1);
      checks++;
      if (bus0.in_ready !== 1'b0 || bus0.dbg_count !== 2'd2) begin
         failures++;
         $display("FAIL ovf_ready_after_b got rdy=%0b cnt=%0d exp rdy=0 cnt=2", bus0.in_ready, bus0.dbg_count);
      end
      rand_frame(); cyc(1);
      in_valid = 1'b0;
      checks++;
      if (bus0.overflow !== 1'b1 || bus1.overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set got=%0b/%0b exp=1", bus0.overflow, bus1.overflow);
      end
      out_ready = 1'b1;
      cyc(16);
      checks++;
      if (beats_seen - b0 != 16 || bus0.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL ovf_drain got beats=%0d valid=%0b exp beats=16 valid=0", beats_seen - b0, bus0.out_valid);
      end
      cyc(3);
      checks++;
      if (bus0.overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky got=%0b exp=1", bus0.overflow);
      end
   endtask

   task automatic test_back_to_back();
      int gaps;
      int b0;
      do_reset();
      out_ready = 1'b1;
      gaps = 0;
      b0 = beats_seen;
      for (int f = 0; f < 5; f++) begin
         rand_frame();
         in_valid = 1'b1;
         cyc(1);
         in_valid = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (bus0.out_valid !== 1'b1) gaps++;
            if (k < 7) cyc(1);
         end
      end
      cyc(10);
      checks++;
      if (gaps != 0) begin
         failures++;
         $display("FAIL b2b_gaps got=%0d exp=0", gaps);
      end
      checks++;
      if (beats_seen - b0 != 40) begin
         failures++;
         $display("FAIL b2b_beats got=%0d exp=40", beats_seen - b0);
      end
   endtask

   task automatic test_bitrev_shift();
      int seq[8];
      do_reset();
      rand_frame();
      drv_f.r[5] = 16'(-7);
      drv_f.i[4] = 16'(16);
      out_ready = 1'b1;
      in_valid = 1'b1;
      cyc(1);
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         seq[k] = int'(bus1.out_idx);
         if (bus1.out_idx == 3'd5) begin
            checks++;
            if (bus1.out_r !== -16'sd2) begin
               failures++;
               $display("FAIL bitrev_idx5_r got=%0d exp=-2", bus1.out_r);
            end
         end
         if (bus1.out_idx == 3'd4) begin
            checks++;
            if (bus1.out_i !== 16'sd4) begin
               failures++;
               $display("FAIL bitrev_idx4_i got=%0d exp=4", bus1.out_i);
            end
         end
         cyc(1);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (seq[k] != rev_tab[k]) begin
            failures++;
            $display("FAIL bitrev_order beat=%0d got=%0d exp=%0d", k, seq[k], rev_tab[k]);
         end
      end
      cyc(2);
   endtask

   task automatic test_async_reset();
      do_reset();
      rand_frame();
      out_ready = 1'b1;
      in_valid = 1'b1;
      cyc(1);
      in_valid = 1'b0;
      cyc(3);
      checks++;
      if (bus0.out_idx !== 3'd3 || bus0.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL arst_pre got idx=%0d valid=%0b exp idx=3 valid=1", bus0.out_idx, bus0.out_valid);
      end
      #2;
      reset = 1'b0;
      model_clear();
      #1;
      checks++;
      if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0 || bus0.dbg_count !== 2'd0) begin
         failures++;
         $display("FAIL arst_drop got valid=%0b/%0b cnt=%0d exp valid=0 cnt=0",
                  bus0.out_valid, bus1.out_valid, bus0.dbg_count);
      end
      cyc(2);
      reset = 1'b1;
      rand_frame();
      in_valid = 1'b1;
      cyc(1);
      in_valid = 1'b0;
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out_idx !== 3'd0 || bus1.out_idx !== 3'd0) begin
         failures++;
         $display("FAIL arst_restart got valid=%0b idx=%0d/%0d exp valid=1 idx=0",
                  bus0.out_valid, bus0.out_idx, bus1.out_idx);
      end
      cyc(10);
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rand_frame();
         in_valid = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         cyc(1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      cyc(20);
      checks++;
      if (exp_q.size() != 0 || bus0.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL random_drain got left=%0d valid=%0b exp left=0 valid=0", exp_q.size(), bus0.out_valid);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_overflow();
      test_back_to_back();
      test_bitrev_shift();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
